// File: rtl/data_mem_responder.sv
// Data-memory responder with a programmable access latency. It serves one load or store at a
// time: a valid/ready request, a WAIT phase of LATENCY cycles, then a held response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DepthW = 30'(DEPTH_WORDS);
  localparam logic [3:0]  Lat    = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_err;
  logic            accept;
  logic            commit;
  logic            cur_write;
  logic            cur_err;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;

  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DepthW);
  assign accept  = (state_q == StIdle) && req_valid;

  // With LATENCY=0 the commit edge is also the accept edge, so live inputs must be used.
  always_comb begin
    if (state_q == StIdle) begin
      cur_write = req_write;
      cur_err   = req_err;
      cur_idx   = req_addr[AW+1:2];
      cur_wdata = req_wdata;
    end else begin
      cur_write = write_q;
      cur_err   = err_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d   = Lat;
          state_d = (Lat != 4'd0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign commit = reset && (state_d == StResp) && (state_q != StResp);

  always_comb begin
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    if (commit) begin
      resp_err_d = cur_err;
      rdata_d    = (cur_write || cur_err) ? 32'd0 : mem[cur_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
      if (accept) begin
        write_q <= req_write;
        err_q   <= req_err;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && cur_write && !cur_err) mem[cur_idx] <= cur_wdata;
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: four instances at LATENCY 2, 0, 15 and 4, driven
// one at a time; a monitor pops expected responses at each response handshake.
module tb_data_mem_responder;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_write;
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [31:0] resp_rdata [4];
  logic [3:0]  resp_err;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY    (g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 15 : 4)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitor samples 1 time unit before each rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    #4;
    for (int i = 0; i < 4; i++) begin
      if (rst_n && resp_valid[i] && resp_ready[i]) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected inst=%0d actual=response required=none", i);
        end else begin
          e = sb_q.pop_front();
          check("sb_inst", 32'(i), 32'(e.inst));
          check("sb_rdata", resp_rdata[i], e.rdata);
          check("sb_err", {31'd0, resp_err[i]}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic do_req(input int i, input int lat, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold);
    int n;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", {31'd0, req_ready[i]}, 32'd1);
    sb_q.push_back('{inst: i, rdata: exp_rdata, err: exp_err});
    @(posedge clk); #1;
    // Scramble inputs to prove the captured copy is used.
    req_valid[i] = 1'b0;
    req_write[i] = ~wr;
    req_addr[i]  = ~addr;
    req_wdata[i] = ~wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("req_ready_busy", {31'd0, req_ready[i]}, 32'd0);
    end while (!resp_valid[i] && n < 40);
    check("latency", 32'(n), 32'(lat + 1));
    check("resp_rdata", resp_rdata[i], exp_rdata);
    check("resp_err", {31'd0, resp_err[i]}, {31'd0, exp_err});
    for (int k = 0; k < hold; k++) begin
      #1;
      req_valid[i] = 1'b1;
      req_write[i] = 1'b1;
      req_addr[i]  = 32'h10;
      req_wdata[i] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, resp_valid[i]}, 32'd1);
      check("hold_rdata", resp_rdata[i], exp_rdata);
      check("hold_err", {31'd0, resp_err[i]}, {31'd0, exp_err});
      check("hold_ready", {31'd0, req_ready[i]}, 32'd0);
    end
    #1;
    resp_ready[i] = 1'b1;
    @(posedge clk); #1;
    resp_ready[i] = 1'b0;
    @(negedge clk);
    check("post_valid", {31'd0, resp_valid[i]}, 32'd0);
    check("post_ready", {31'd0, req_ready[i]}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    resp_ready = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    #2;
    for (int i = 0; i < 4; i++) begin
      check("rst_valid", {31'd0, resp_valid[i]}, 32'd0);
      check("rst_rdata", resp_rdata[i], 32'd0);
      check("rst_err", {31'd0, resp_err[i]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {28'd0, req_ready}, 32'hF);

    // Store then load, LATENCY=2
    do_req(0, 2, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
    do_req(0, 2, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
    // Latency sweep
    do_req(1, 0, 1'b1, 32'h04, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
    do_req(1, 0, 1'b0, 32'h04, 32'd0, 32'hCAFE_F00D, 1'b0, 0);
    do_req(2, 15, 1'b1, 32'h04, 32'h0123_4567, 32'd0, 1'b0, 0);
    do_req(2, 15, 1'b0, 32'h04, 32'd0, 32'h0123_4567, 1'b0, 0);
    // Misaligned store leaves storage untouched
    do_req(0, 2, 1'b1, 32'h20, 32'h55AA_55AA, 32'd0, 1'b0, 0);
    do_req(0, 2, 1'b1, 32'h22, 32'h1234_5678, 32'd0, 1'b1, 0);
    do_req(0, 2, 1'b0, 32'h20, 32'd0, 32'h55AA_55AA, 1'b0, 0);
    do_req(0, 2, 1'b0, 32'h21, 32'd0, 32'd0, 1'b1, 0);
    // Out of range, then backpressure with ignored request pulses
    do_req(0, 2, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1, 0);
    do_req(1, 0, 1'b1, 32'h400, 32'h7777_7777, 32'd0, 1'b1, 0);
    do_req(0, 2, 1'b1, 32'h3FC, 32'h0BAD_CAFE, 32'd0, 1'b0, 0);
    do_req(0, 2, 1'b0, 32'h3FC, 32'd0, 32'h0BAD_CAFE, 1'b0, 5);
    do_req(0, 2, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);

    // Reset during WAIT drops the pending store
    do_req(3, 4, 1'b1, 32'h08, 32'h1111_2222, 32'd0, 1'b0, 0);
    do_req(3, 4, 1'b0, 32'h08, 32'd0, 32'h1111_2222, 1'b0, 0);
    @(posedge clk); #1;
    req_valid[3] = 1'b1;
    req_write[3] = 1'b1;
    req_addr[3]  = 32'h08;
    req_wdata[3] = 32'hA5A5_A5A5;
    @(negedge clk);
    check("rst_test_accept", {31'd0, req_ready[3]}, 32'd1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, resp_valid[3]}, 32'd0);
    check("midrst_rdata", resp_rdata[3], 32'd0);
    check("midrst_err", {31'd0, resp_err[3]}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, req_ready[3]}, 32'd1);
    repeat (6) @(negedge clk);
    check("midrst_idle", {31'd0, resp_valid[3]}, 32'd0);
    do_req(3, 4, 1'b0, 32'h08, 32'd0, 32'h1111_2222, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
